// File: rtl/alu_seq_n.sv
// alu_seq_n: sequential N-bit ALU with a request/response handshake.
// Single-cycle ops complete at the accept edge. Divide and modulo run a
// restoring shift-subtract divider that produces one quotient bit per cycle.
module alu_seq_n #(
  parameter int N  = 64,
  parameter int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [5:0]   sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [N-1:0] upper_result,
  output logic         carry_flag,
  output logic         overflow_flag,
  output logic         zero_flag,
  output logic         negative_flag,
  output logic         parity_flag,
  output logic         modulo_flag,
  output logic         div_zero_flag
);

  localparam int CW = $clog2(N);
  localparam logic [SW:0]  N_AMT = (SW+1)'(N);
  localparam logic [N-1:0] ONE_N = N'(1'b1);
  localparam logic [N-1:0] ZERO_N = {N{1'b0}};

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2} state_t;

  state_t state_r, state_nx_s;

  logic [5:0]    sel_r;
  logic [N-1:0]  b_r, quo_r, rem_r;
  logic [CW-1:0] cnt_r;

  logic accept_s, is_div_s, b_zero_s, last_s;
  logic [N:0]   rem_sh_s, rem_diff_s;
  logic [N-1:0] quo_nx_s, rem_nx_s;

  logic [N:0]     add_s;
  logic [2*N-1:0] mul_s;
  logic [SW-1:0]  amt_s;
  logic [SW:0]    amt_inv_s;
  logic [N-1:0]   alu_res_s, alu_up_s;
  logic           alu_c_s, alu_v_s;

  logic           ld_en_s, ld_c_s, ld_v_s, ld_mod_s, ld_dz_s;
  logic [N-1:0]   ld_res_s, ld_up_s;

  // Even parity: 1 when the word carries an even number of ones.
  function automatic logic even_parity(input logic [N-1:0] v);
    return ~^v;
  endfunction

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign accept_s  = in_valid & in_ready;
  assign is_div_s  = (sel == 6'd3) || (sel == 6'd8);
  assign b_zero_s  = (b == ZERO_N);
  assign last_s    = (state_r == DIV) && (cnt_r == CW'(N - 1));

  // One restoring-division step: shift in the next dividend bit, try subtract.
  always_comb begin
    rem_sh_s   = {rem_r, quo_r[N-1]};
    rem_diff_s = rem_sh_s - {1'b0, b_r};
    if (!rem_diff_s[N]) begin
      rem_nx_s = rem_diff_s[N-1:0];
      quo_nx_s = {quo_r[N-2:0], 1'b1};
    end else begin
      rem_nx_s = rem_sh_s[N-1:0];
      quo_nx_s = {quo_r[N-2:0], 1'b0};
    end
  end

  // Single-cycle datapath evaluated on the live request operands.
  always_comb begin
    add_s     = {1'b0, a} + {1'b0, b};
    mul_s     = {ZERO_N, a} * {ZERO_N, b};
    amt_s     = b[SW-1:0];
    amt_inv_s = N_AMT - {1'b0, amt_s};
    alu_res_s = ZERO_N;
    alu_up_s  = ZERO_N;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (sel)
      6'd0: begin
        alu_res_s = add_s[N-1:0];
        alu_c_s   = add_s[N];
        alu_v_s   = (a[N-1] == b[N-1]) && (add_s[N-1] != a[N-1]);
      end
      6'd1: begin
        alu_res_s = a - b;
        alu_c_s   = (a < b);
        alu_v_s   = (a[N-1] != b[N-1]) && (alu_res_s[N-1] != a[N-1]);
      end
      6'd2: begin
        alu_res_s = mul_s[N-1:0];
        alu_up_s  = mul_s[2*N-1:N];
      end
      6'd4:  alu_res_s = a + ONE_N;
      6'd5:  alu_res_s = b + ONE_N;
      6'd6:  alu_res_s = a - ONE_N;
      6'd7:  alu_res_s = b - ONE_N;
      6'd9:  alu_res_s = a & b;
      6'd10: alu_res_s = a | b;
      6'd11: alu_res_s = ~a;
      6'd12: alu_res_s = ~b;
      6'd13: alu_res_s = ~(a & b);
      6'd14: alu_res_s = ~(a | b);
      6'd15: alu_res_s = a ^ b;
      6'd16: alu_res_s = ~(a ^ b);
      6'd17: alu_res_s = a << amt_s;
      6'd18: alu_res_s = a >> amt_s;
      6'd19: alu_res_s = $signed(a) >>> amt_s;
      6'd20: alu_res_s = (a << amt_s) | (a >> amt_inv_s);
      6'd21: alu_res_s = (a >> amt_s) | (a << amt_inv_s);
      6'd22: alu_res_s = {{(N-1){1'b0}}, (a == b)};
      6'd23: alu_res_s = {{(N-1){1'b0}}, (a != b)};
      6'd24: alu_res_s = {{(N-1){1'b0}}, (a < b)};
      6'd25: alu_res_s = {{(N-1){1'b0}}, (a > b)};
      6'd26: alu_res_s = {{(N-1){1'b0}}, (a <= b)};
      6'd27: alu_res_s = {{(N-1){1'b0}}, (a >= b)};
      6'd28: alu_res_s = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      6'd29: alu_res_s = {{(N-1){1'b0}}, ($signed(a) > $signed(b))};
      default: alu_res_s = ZERO_N;
    endcase
  end

  // Select what, if anything, is written to the output registers this cycle.
  always_comb begin
    ld_en_s  = 1'b0;
    ld_res_s = ZERO_N;
    ld_up_s  = ZERO_N;
    ld_c_s   = 1'b0;
    ld_v_s   = 1'b0;
    ld_mod_s = 1'b0;
    ld_dz_s  = 1'b0;
    if (accept_s) begin
      if (is_div_s) begin
        if (b_zero_s) begin
          ld_en_s = 1'b1;
          ld_dz_s = 1'b1;
        end else begin
          ld_en_s = 1'b0;
        end
      end else begin
        ld_en_s  = 1'b1;
        ld_res_s = alu_res_s;
        ld_up_s  = alu_up_s;
        ld_c_s   = alu_c_s;
        ld_v_s   = alu_v_s;
      end
    end else if (last_s) begin
      ld_en_s  = 1'b1;
      ld_mod_s = (rem_nx_s != ZERO_N);
      if (sel_r == 6'd3) begin
        ld_res_s = quo_nx_s;
      end else begin
        ld_res_s = rem_nx_s;
      end
    end else begin
      ld_en_s = 1'b0;
    end
  end

  // Next-state logic for the IDLE / DIV / DONE handshake.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (is_div_s && !b_zero_s) begin
            state_nx_s = DIV;
          end else begin
            state_nx_s = DONE;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      DIV: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = DIV;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand capture and divider iteration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_r <= 6'd0;
      b_r   <= ZERO_N;
      quo_r <= ZERO_N;
      rem_r <= ZERO_N;
      cnt_r <= {CW{1'b0}};
    end else if (accept_s) begin
      sel_r <= sel;
      b_r   <= b;
      quo_r <= a;
      rem_r <= ZERO_N;
      cnt_r <= {CW{1'b0}};
    end else if (state_r == DIV) begin
      quo_r <= quo_nx_s;
      rem_r <= rem_nx_s;
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Result and flag registers; they hold their value until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result        <= ZERO_N;
      upper_result  <= ZERO_N;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
      zero_flag     <= 1'b0;
      negative_flag <= 1'b0;
      parity_flag   <= 1'b0;
      modulo_flag   <= 1'b0;
      div_zero_flag <= 1'b0;
    end else if (ld_en_s) begin
      result        <= ld_res_s;
      upper_result  <= ld_up_s;
      carry_flag    <= ld_c_s;
      overflow_flag <= ld_v_s;
      zero_flag     <= (ld_res_s == ZERO_N);
      negative_flag <= ld_res_s[N-1];
      parity_flag   <= even_parity(ld_res_s);
      modulo_flag   <= ld_mod_s;
      div_zero_flag <= ld_dz_s;
    end
  end

endmodule

// File: tb/tb_alu_seq_n.sv
// Bench for alu_seq_n: an 8-bit and a 64-bit instance, directed corner cases
// plus random requests compared against an arithmetic reference model.
module tb_alu_seq_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv8, iv64, out_ready;
  logic [63:0] a_bus, b_bus;
  logic [5:0]  sel_bus;

  logic        rdy8, ov8, c8, v8, z8, n8, p8, m8, d8;
  logic [7:0]  res8, up8;
  logic        rdy64, ov64, c64, v64, z64, n64, p64, m64, d64;
  logic [63:0] res64, up64;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq_n #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8),
    .a(a_bus[7:0]), .b(b_bus[7:0]), .sel(sel_bus),
    .out_valid(ov8), .out_ready(out_ready),
    .result(res8), .upper_result(up8),
    .carry_flag(c8), .overflow_flag(v8), .zero_flag(z8), .negative_flag(n8),
    .parity_flag(p8), .modulo_flag(m8), .div_zero_flag(d8)
  );

  alu_seq_n #(.N(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(rdy64),
    .a(a_bus), .b(b_bus), .sel(sel_bus),
    .out_valid(ov64), .out_ready(out_ready),
    .result(res64), .upper_result(up64),
    .carry_flag(c64), .overflow_flag(v64), .zero_flag(z64), .negative_flag(n64),
    .parity_flag(p64), .modulo_flag(m64), .div_zero_flag(d64)
  );

  // Observation mux: view whichever instance the current operation targets.
  logic        use64;
  logic        o_valid, o_ready;
  logic [63:0] o_res, o_up;
  logic [6:0]  o_fl;
  always_comb begin
    if (use64) begin
      o_valid = ov64; o_ready = rdy64; o_res = res64; o_up = up64;
      o_fl = {c64, v64, z64, n64, p64, m64, d64};
    end else begin
      o_valid = ov8; o_ready = rdy8; o_res = {56'd0, res8}; o_up = {56'd0, up8};
      o_fl = {c8, v8, z8, n8, p8, m8, d8};
    end
  end

  typedef struct packed {
    logic [63:0] res;
    logic [63:0] up;
    logic [6:0]  fl;   // {carry, overflow, zero, negative, parity, modulo, div_zero}
  } exp_t;

  // Reference model: plain wide arithmetic masked to w bits.
  function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                 input logic [5:0] s);
    exp_t e;
    logic [127:0] mask, x, y, sx, sy, full;
    int amt;
    logic c, v, md, dz;
    longint sa, sb;
    mask = (128'd1 << w) - 128'd1;
    x = {64'd0, av} & mask;
    y = {64'd0, bv} & mask;
    sx = x[w-1] ? (x | ~mask) : x;
    sy = y[w-1] ? (y | ~mask) : y;
    sa = $signed(sx[63:0]);
    sb = $signed(sy[63:0]);
    amt = int'(y % 128'(w));
    full = 128'd0; c = 1'b0; v = 1'b0; md = 1'b0; dz = 1'b0; e.up = 64'd0;
    case (s)
      6'd0: begin full = x + y; c = full[w]; v = (x[w-1] == y[w-1]) && (full[w-1] != x[w-1]); end
      6'd1: begin full = (x - y) & mask; c = (x < y); v = (x[w-1] != y[w-1]) && (full[w-1] != x[w-1]); end
      6'd2: begin full = x * y; e.up = 64'((full >> w) & mask); end
      6'd3: begin if (y == 0) dz = 1'b1; else begin full = x / y; md = ((x % y) != 0); end end
      6'd8: begin if (y == 0) dz = 1'b1; else begin full = x % y; md = (full != 0); end end
      6'd4:  full = x + 1;
      6'd5:  full = y + 1;
      6'd6:  full = x - 1;
      6'd7:  full = y - 1;
      6'd9:  full = x & y;
      6'd10: full = x | y;
      6'd11: full = ~x;
      6'd12: full = ~y;
      6'd13: full = ~(x & y);
      6'd14: full = ~(x | y);
      6'd15: full = x ^ y;
      6'd16: full = ~(x ^ y);
      6'd17: full = x << amt;
      6'd18: full = x >> amt;
      6'd19: full = sx >> amt;
      6'd20: full = (x << amt) | (x >> (w - amt));
      6'd21: full = (x >> amt) | (x << (w - amt));
      6'd22: full = (x == y) ? 128'd1 : 128'd0;
      6'd23: full = (x != y) ? 128'd1 : 128'd0;
      6'd24: full = (x <  y) ? 128'd1 : 128'd0;
      6'd25: full = (x >  y) ? 128'd1 : 128'd0;
      6'd26: full = (x <= y) ? 128'd1 : 128'd0;
      6'd27: full = (x >= y) ? 128'd1 : 128'd0;
      6'd28: full = (sa < sb) ? 128'd1 : 128'd0;
      6'd29: full = (sa > sb) ? 128'd1 : 128'd0;
      default: full = 128'd0;
    endcase
    full = full & mask;
    e.res = full[63:0];
    e.fl = {c, v, (full == 0), full[w-1], ($countones(full) % 2 == 0), md, dz};
    return e;
  endfunction

  // Single comparison point: counts and reports.
  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One request: issue, scramble inputs, wait for result, check, optionally
  // stall with out_ready low while poking the inputs, then release.
  task automatic do_op(input int w, input logic [63:0] av, input logic [63:0] bv,
                       input logic [5:0] s, input int hold,
                       output logic [63:0] ores, output logic [63:0] oup, output logic [6:0] ofl);
    exp_t e;
    int cyc, lat;
    logic [63:0] bw;
    e = model(w, av, bv, s);
    bw = (w == 64) ? bv : (bv & ((64'd1 << w) - 64'd1));
    lat = ((s == 6'd3 || s == 6'd8) && bw != 64'd0) ? w + 1 : 1;
    use64 = (w == 64);
    @(negedge clk);
    check_val("in_ready", o_ready, 1);
    a_bus = av; b_bus = bv; sel_bus = s;
    if (w == 64) iv64 = 1'b1; else iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0; iv64 = 1'b0;
    a_bus = {$urandom, $urandom}; b_bus = {$urandom, $urandom};
    sel_bus = 6'($urandom_range(0, 63));
    cyc = 1;
    while (!o_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_val("out_valid", o_valid, 1);
    check_val("latency", cyc, lat);
    check_val("result", o_res, e.res);
    check_val("upper", o_up, e.up);
    check_val("flags", o_fl, e.fl);
    ores = o_res; oup = o_up; ofl = o_fl;
    for (int k = 0; k < hold; k++) begin
      a_bus = {$urandom, $urandom}; b_bus = {$urandom, $urandom};
      sel_bus = 6'($urandom_range(0, 63));
      if (w == 64) iv64 = 1'b1; else iv8 = 1'b1;
      @(negedge clk);
      check_val("hold_valid", o_valid, 1);
      check_val("hold_ready", o_ready, 0);
      check_val("hold_res", o_res, e.res);
      check_val("hold_flags", o_fl, e.fl);
    end
    iv8 = 1'b0; iv64 = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val("idle_valid", o_valid, 0);
    check_val("idle_res", o_res, e.res);
  endtask

  function automatic logic [63:0] pick(input int w);
    logic [63:0] m, r;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0: r = 64'd0;
      1: r = m;
      2: r = (m >> 1) + 64'd1;
      3: r = m >> 1;
      4: r = 64'd1;
      default: r = {$urandom, $urandom};
    endcase
    return r & m;
  endfunction

  logic [63:0] r, u;
  logic [6:0]  f;

  initial begin
    rst = 1'b1; iv8 = 1'b0; iv64 = 1'b0; out_ready = 1'b0;
    a_bus = 64'd0; b_bus = 64'd0; sel_bus = 6'd0; use64 = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_valid", o_valid, 0);
    check_val("rst_ready", o_ready, 1);
    check_val("rst_res", o_res, 0);
    check_val("rst_flags", o_fl, 0);
    rst = 1'b0;

    do_op(8, 64'hFF, 64'h01, 6'd0, 0, r, u, f);
    check_val("add_wrap_res", r, 64'h00);
    check_val("add_wrap_fl", f, 7'b1010100);

    do_op(8, 64'd100, 64'd7, 6'd3, 0, r, u, f);
    check_val("div_res", r, 64'd14);
    check_val("div_mod", f[1], 1);
    do_op(8, 64'd100, 64'd7, 6'd8, 0, r, u, f);
    check_val("mod_res", r, 64'd2);

    do_op(64, 64'd1234, 64'd0, 6'd3, 0, r, u, f);
    check_val("dz_res", r, 64'd0);
    check_val("dz_flag", f[0], 1);
    do_op(64, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'd2, 0, r, u, f);
    check_val("mul_lo", r, 64'd0);
    check_val("mul_hi", u, 64'h4000_0000_0000_0000);

    do_op(8, 64'h81, 64'd3, 6'd20, 0, r, u, f);
    check_val("rotl", r, 64'h0C);
    do_op(8, 64'h81, 64'd0, 6'd21, 0, r, u, f);
    check_val("rotr0", r, 64'h81);
    do_op(8, 64'h80, 64'd2, 6'd19, 0, r, u, f);
    check_val("sra", r, 64'hE0);
    check_val("sra_neg", f[3], 1);
    do_op(8, 64'hFF, 64'd0, 6'd4, 0, r, u, f);
    check_val("inc_wrap", r, 64'd0);
    check_val("inc_zero", f[4], 1);

    do_op(8, 64'h5A, 64'h3C, 6'd15, 5, r, u, f);

    // Reset in the middle of an 8-bit divide.
    use64 = 1'b0;
    @(negedge clk);
    a_bus = 64'd100; b_bus = 64'd7; sel_bus = 6'd3; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_valid", o_valid, 0);
    check_val("midrst_ready", o_ready, 1);
    check_val("midrst_res", o_res, 0);
    check_val("midrst_fl", o_fl, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_val("midrst_no_out", o_valid, 0);
    do_op(8, 64'd3, 64'd5, 6'd1, 0, r, u, f);
    check_val("sub_res", r, 64'hFE);
    check_val("sub_fl", f, 7'b1001000);

    for (int i = 0; i < 300; i++) begin
      do_op(8, pick(8), pick(8), 6'($urandom_range(0, 35)), $urandom_range(0, 2), r, u, f);
    end
    for (int i = 0; i < 60; i++) begin
      do_op(64, pick(64), pick(64), 6'($urandom_range(0, 35)), $urandom_range(0, 1), r, u, f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
